sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Owns the shared SDRAM command/address bus and sequences the init, auto-refresh, write and read sub-controllers.
- Holds the bus in INIT until initialisation completes, then grants one owner at a time.
- Priority is refresh > write > read. Refresh can preempt an in-flight write or read burst through wr_wait/rd_wait.
- Sits between the sub-controllers and the SDRAM pin interface; a watchdog recovers from owners that never signal end.

Parameters:
- CMD_NOP, 4'b0111, encoding {CS_n,RAS_n,CAS_n,WE_n} driven when no owner.
- OWN_TIMEOUT, 10'd600, max cycles an owner may hold the bus before forced release.

Ports:
- sys_clk  in  1  system clock, 100 MHz.
- sys_rst_n  in  1  async active-low reset.
- init_done  in  1  init sequence complete (level).
- init_cmd/init_ba/init_addr  in  4/2/12  init command bus.
- aref_req  in  1  refresh due (level, held until granted).
- aref_end  in  1  refresh finished pulse.
- aref_cmd/aref_ba/aref_addr  in  4/2/12  refresh command bus.
- wr_req  in  1  write pending (level).
- wr_end  in  1  write burst finished pulse.
- wr_cmd/wr_ba/wr_addr  in  4/2/12  write command bus.
- rd_req  in  1  read pending (level).
- rd_end  in  1  read burst finished pulse.
- rd_cmd/rd_ba/rd_addr  in  4/2/12  read command bus.
- aref_en/wr_en/rd_en  out  1 each  one-cycle grant pulse.
- wr_wait/rd_wait  out  1 each  level request to terminate the burst early for refresh.
- sdram_cmd/sdram_ba/sdram_addr  out  4/2/12  muxed bus to the pins.
- wr_dq_oe  out  1  high while WRITE owns the bus.
- arb_err  out  1  one-cycle pulse on watchdog release.

Behaviour:
- Reset (async): state=INIT; all en/wait/arb_err/wr_dq_oe=0; timer=0.
- INIT: mux selects init bus. Stays until init_done=1, then moves to ARBIT next edge.
- ARBIT: bus outputs sdram_cmd=CMD_NOP, sdram_ba=2'b11, sdram_addr=12'hFFF.
  - Same-cycle choice: aref_req → AREF; else wr_req → WRITE; else rd_req → READ; else stay.
  - Simultaneous requests resolve by priority only.
- Owner states AREF, WRITE, READ:
  - The matching *_en is a registered pulse, high exactly in the first cycle of the state.
  - Mux selects that owner's cmd/ba/addr combinationally.
  - Owner's *_end → ARBIT next edge. The ARBIT cycle always costs one NOP cycle between owners.
- Preemption:
  - In WRITE with aref_req=1: wr_wait=1 from the next cycle until wr_end; cleared on the state exit edge.
  - READ/rd_wait behave identically.
  - After wr_end/rd_end, ARBIT grants AREF because refresh has priority.
  - An interrupted requester keeps its *_req high and is re-granted later.
- wr_dq_oe = (state==WRITE).
- Watchdog:
  - 10-bit timer clears on entry to each owner state and increments each owner cycle.
  - At timer==OWN_TIMEOUT-1 with no end: force ARBIT, pulse arb_err, drop wait.
  - Not active in INIT or ARBIT.
- Edge cases:
  - *_end arriving in ARBIT or from a non-owner is ignored.
  - *_end in the same cycle as timeout counts as normal end; no arb_err.
  - Reset mid-burst returns to INIT immediately.
  - init_done falling after INIT is ignored.

Optional Feature:
- Macro: SDRAM_ARB_RR_EN.
- Defined: write/read arbitration is round-robin. A 1-bit last_grant flag (reset=read) makes the non-last-served of wr/rd win when both request. Refresh still outranks both.
- Undefined: fixed write > read priority; no last_grant register.

Test Plan:
- Reset, init_done=0 for 20 cycles, init_cmd=4'b0010 → sdram_cmd=4'b0010 throughout; no en pulses. Raise init_done → ARBIT, sdram_cmd=4'b0111.
- wr_req=rd_req=1 in ARBIT → wr_en pulses 1 cycle. wr_end after 10 cycles → one NOP cycle, then rd_en pulse. With SDRAM_ARB_RR_EN, a second simultaneous request after the read grants write; without it, write still wins.
- WRITE active, aref_req raised at cycle 3 → wr_wait=1 at cycle 4. wr_end at cycle 6 → wr_wait=0, ARBIT, then aref_en pulse. wr_req still high → re-granted after aref_end.
- aref_req, wr_req, rd_req all rise together → aref_en first; wr_dq_oe=0 during AREF.
- Grant read with rd_end never asserted → after exactly 600 owner cycles arb_err pulses once and state returns to ARBIT.
- Assert sys_rst_n=0 mid-WRITE → outputs zero asynchronously, sdram_cmd=init_cmd, state INIT.

Source files
------------

// File: rtl/sdram_arbiter.sv
// SDRAM command-bus arbiter: INIT hand-off, then refresh > write > read ownership with a watchdog.
// Optional SDRAM_ARB_RR_EN: round-robin between write and read instead of fixed write-first.
module sdram_arbiter #(
    parameter logic [3:0] CMD_NOP     = 4'b0111,
    parameter logic [9:0] OWN_TIMEOUT = 10'd600
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_done,
    input  logic [3:0]  init_cmd,
    input  logic [1:0]  init_ba,
    input  logic [11:0] init_addr,
    input  logic        aref_req,
    input  logic        aref_end,
    input  logic [3:0]  aref_cmd,
    input  logic [1:0]  aref_ba,
    input  logic [11:0] aref_addr,
    input  logic        wr_req,
    input  logic        wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [1:0]  wr_ba,
    input  logic [11:0] wr_addr,
    input  logic        rd_req,
    input  logic        rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [1:0]  rd_ba,
    input  logic [11:0] rd_addr,
    output logic        aref_en,
    output logic        wr_en,
    output logic        rd_en,
    output logic        wr_wait,
    output logic        rd_wait,
    output logic [3:0]  sdram_cmd,
    output logic [1:0]  sdram_ba,
    output logic [11:0] sdram_addr,
    output logic        wr_dq_oe,
    output logic        arb_err
);

    typedef enum logic [2:0] {INIT, ARBIT, AREF, WRITE, READ} state_t;

    state_t      state, state_nxt;
    logic [9:0]  timer;
    logic        owner, own_end, timeout, wr_sel;

`ifdef SDRAM_ARB_RR_EN
    logic last_grant;  // 1 = write served last, 0 = read served last

    assign wr_sel = wr_req && !(rd_req && last_grant);
`else
    assign wr_sel = wr_req;
`endif

    assign owner = (state == AREF) || (state == WRITE) || (state == READ);

    always_comb begin
        state_nxt = state;
        own_end   = 1'b0;
        case (state)
            INIT:    if (init_done) state_nxt = ARBIT;
            ARBIT: begin
                if (aref_req)     state_nxt = AREF;
                else if (wr_sel)  state_nxt = WRITE;
                else if (rd_req)  state_nxt = READ;
            end
            AREF:    own_end = aref_end;
            WRITE:   own_end = wr_end;
            READ:    own_end = rd_end;
            default: state_nxt = INIT;
        endcase
        // A real end on the timeout cycle wins over the watchdog.
        timeout = owner && (timer == OWN_TIMEOUT - 10'd1) && !own_end;
        if (owner && (own_end || timeout)) state_nxt = ARBIT;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= INIT;
            timer   <= 10'd0;
            aref_en <= 1'b0;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
            wr_wait <= 1'b0;
            rd_wait <= 1'b0;
            arb_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            timer   <= (owner && state_nxt == state) ? timer + 10'd1 : 10'd0;
            aref_en <= (state == ARBIT) && (state_nxt == AREF);
            wr_en   <= (state == ARBIT) && (state_nxt == WRITE);
            rd_en   <= (state == ARBIT) && (state_nxt == READ);
            // Sticky until the burst's exit edge.
            wr_wait <= (state == WRITE) && (state_nxt == WRITE) && (aref_req || wr_wait);
            rd_wait <= (state == READ) && (state_nxt == READ) && (aref_req || rd_wait);
            arb_err <= timeout;
        end
    end

`ifdef SDRAM_ARB_RR_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            last_grant <= 1'b0;
        end else if (state == ARBIT) begin
            if (state_nxt == WRITE)     last_grant <= 1'b1;
            else if (state_nxt == READ) last_grant <= 1'b0;
        end
    end
`endif

    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_ba   = 2'b11;
        sdram_addr = 12'hFFF;
        case (state)
            INIT: begin
                sdram_cmd  = init_cmd;
                sdram_ba   = init_ba;
                sdram_addr = init_addr;
            end
            AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_ba   = aref_ba;
                sdram_addr = aref_addr;
            end
            WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_ba   = wr_ba;
                sdram_addr = wr_addr;
            end
            READ: begin
                sdram_cmd  = rd_cmd;
                sdram_ba   = rd_ba;
                sdram_addr = rd_addr;
            end
            default: ;
        endcase
    end

    assign wr_dq_oe = (state == WRITE);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: fixed vector table, watchdog/reset sequences, random run vs. an ownership model.
module tb_sdram_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        init_done = 1'b0;
    logic [3:0]  init_cmd = 4'b0010;
    logic [1:0]  init_ba = 2'd0;
    logic [11:0] init_addr = 12'h100;
    logic        aref_req = 1'b0, aref_end = 1'b0;
    logic [3:0]  aref_cmd = 4'b0001;
    logic [1:0]  aref_ba = 2'd1;
    logic [11:0] aref_addr = 12'h200;
    logic        wr_req = 1'b0, wr_end = 1'b0;
    logic [3:0]  wr_cmd = 4'b0100;
    logic [1:0]  wr_ba = 2'd2;
    logic [11:0] wr_addr = 12'h300;
    logic        rd_req = 1'b0, rd_end = 1'b0;
    logic [3:0]  rd_cmd = 4'b0101;
    logic [1:0]  rd_ba = 2'd3;
    logic [11:0] rd_addr = 12'h400;
    logic        aref_en, wr_en, rd_en, wr_wait, rd_wait, wr_dq_oe, arb_err;
    logic [3:0]  sdram_cmd;
    logic [1:0]  sdram_ba;
    logic [11:0] sdram_addr;

    sdram_arbiter dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_done(init_done),
        .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
        .aref_req(aref_req), .aref_end(aref_end),
        .aref_cmd(aref_cmd), .aref_ba(aref_ba), .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
        .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .wr_wait(wr_wait), .rd_wait(rd_wait),
        .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
        .wr_dq_oe(wr_dq_oe), .arb_err(arb_err)
    );

    always #5 sys_clk = ~sys_clk;

    int errs = 0;
    int checks = 0;

`ifdef SDRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Ownership model: -1 = initialising, 0 = bus idle, 1 = refresh, 2 = write, 3 = read.
    int m_own, m_held;
    bit m_fresh, m_pre, m_err, m_last_wr;

    task automatic model_reset();
        m_own = -1; m_held = 0; m_fresh = 0; m_pre = 0; m_err = 0; m_last_wr = 0;
    endtask

    task automatic model_check(input string tag);
        logic [3:0]  c;
        logic [1:0]  b;
        logic [11:0] a;
        case (m_own)
            -1: begin c = init_cmd; b = init_ba; a = init_addr; end
            1:  begin c = aref_cmd; b = aref_ba; a = aref_addr; end
            2:  begin c = wr_cmd;   b = wr_ba;   a = wr_addr;   end
            3:  begin c = rd_cmd;   b = rd_ba;   a = rd_addr;   end
            default: begin c = 4'b0111; b = 2'b11; a = 12'hFFF; end
        endcase
        chk(tag,
            {7'd0, sdram_cmd, sdram_ba, sdram_addr, aref_en, wr_en, rd_en, wr_wait, rd_wait, wr_dq_oe, arb_err},
            {7'd0, c, b, a, m_fresh && m_own == 1, m_fresh && m_own == 2, m_fresh && m_own == 3,
             m_pre && m_own == 2, m_pre && m_own == 3, m_own == 2, m_err});
    endtask

    task automatic model_step();
        int nxt;
        bit e;
        m_err = 0;
        m_fresh = 0;
        if (m_own == -1) begin
            if (init_done) m_own = 0;
        end else if (m_own == 0) begin
            nxt = 0;
            if (aref_req) nxt = 1;
            else if (wr_req && rd_req) nxt = (RR && m_last_wr) ? 3 : 2;
            else if (wr_req) nxt = 2;
            else if (rd_req) nxt = 3;
            if (nxt != 0) begin
                m_own = nxt; m_fresh = 1; m_held = 0; m_pre = 0;
                if (nxt == 2) m_last_wr = 1;
                if (nxt == 3) m_last_wr = 0;
            end
        end else begin
            e = (m_own == 1) ? aref_end : (m_own == 2) ? wr_end : rd_end;
            m_held++;
            if (e) begin
                m_own = 0; m_pre = 0;
            end else if (m_held == 600) begin
                m_own = 0; m_err = 1; m_pre = 0;
            end else if (aref_req && m_own != 1) begin
                m_pre = 1;
            end
        end
    endtask

    task automatic cycle(input string tag);
        @(negedge sys_clk);
        model_check(tag);
        model_step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        init_done = 0; aref_req = 0; aref_end = 0; wr_req = 0; wr_end = 0; rd_req = 0; rd_end = 0;
        #2 sys_rst_n = 0;
        #1 chk("reset_out", {sdram_cmd, aref_en, wr_en, rd_en, wr_wait, rd_wait, wr_dq_oe, arb_err},
               {init_cmd, 7'd0});
        repeat (2) @(posedge sys_clk);
        #1 sys_rst_n = 1;
        model_reset();
    endtask

    typedef struct {
        logic [6:0] in;    // init_done, aref_req, wr_req, rd_req, aref_end, wr_end, rd_end
        logic [3:0] cmd;
        logic [2:0] en;    // aref_en, wr_en, rd_en
        logic [1:0] wt;    // wr_wait, rd_wait
        logic       oe;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{7'b1000000, 4'b0010, 3'b000, 2'b00, 1'b0};  // INIT, init_done rises
        tbl[1]  = '{7'b1011001, 4'b0111, 3'b000, 2'b00, 1'b0};  // ARBIT, stray rd_end ignored
        tbl[2]  = '{7'b1011000, 4'b0100, 3'b010, 2'b00, 1'b1};  // write wins
        tbl[3]  = '{7'b1111001, 4'b0100, 3'b000, 2'b00, 1'b1};  // refresh due, non-owner end
        tbl[4]  = '{7'b1111010, 4'b0100, 3'b000, 2'b10, 1'b1};  // wr_wait, write ends
        tbl[5]  = '{7'b1111000, 4'b0111, 3'b000, 2'b00, 1'b0};  // NOP gap
        tbl[6]  = '{7'b0011000, 4'b0001, 3'b100, 2'b00, 1'b0};  // refresh, init_done drop ignored
        tbl[7]  = '{7'b0011100, 4'b0001, 3'b000, 2'b00, 1'b0};
        tbl[8]  = '{7'b0011000, 4'b0111, 3'b000, 2'b00, 1'b0};
        if (RR) begin
            tbl[9]  = '{7'b0011000, 4'b0101, 3'b001, 2'b00, 1'b0};
            tbl[10] = '{7'b0000011, 4'b0101, 3'b000, 2'b00, 1'b0};
        end else begin
            tbl[9]  = '{7'b0011000, 4'b0100, 3'b010, 2'b00, 1'b1};
            tbl[10] = '{7'b0000011, 4'b0100, 3'b000, 2'b00, 1'b1};
        end
        tbl[11] = '{7'b0000000, 4'b0111, 3'b000, 2'b00, 1'b0};

        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            chk("init_hold", {sdram_cmd, aref_en, wr_en, rd_en}, {4'b0010, 3'b000});
        end
        @(posedge sys_clk); #1;
        for (int i = 0; i < 12; i++) begin
            {init_done, aref_req, wr_req, rd_req, aref_end, wr_end, rd_end} = tbl[i].in;
            @(negedge sys_clk);
            chk($sformatf("vec%0d", i), {sdram_cmd, aref_en, wr_en, rd_en, wr_wait, rd_wait, wr_dq_oe},
                {tbl[i].cmd, tbl[i].en, tbl[i].wt, tbl[i].oe});
            @(posedge sys_clk); #1;
        end

        // Watchdog: read owner never ends.
        do_reset();
        init_done = 1; rd_req = 1;
        cycle("wd_init"); cycle("wd_arbit");
        rd_req = 0;
        repeat (600) cycle("wd_hold");
        chk("wd_release", {arb_err, sdram_cmd}, {1'b1, 4'b0111});
        rd_req = 1;
        cycle("wd_arbit2");
        chk("wd_err_single", arb_err, 1'b0);
        rd_req = 0;
        repeat (599) cycle("wd_hold2");
        rd_end = 1;
        cycle("wd_end_at_limit");
        rd_end = 0;
        chk("wd_end_no_err", {arb_err, sdram_cmd}, {1'b0, 4'b0111});

        // Read preempted by refresh, then async reset in the middle of a write.
        do_reset();
        init_done = 1; rd_req = 1;
        cycle("pre_init"); cycle("pre_arbit"); cycle("pre_rd1");
        aref_req = 1;
        cycle("pre_rd2"); cycle("pre_rd_wait");
        chk("rd_wait_set", rd_wait, 1'b1);
        rd_end = 1; cycle("pre_rd_end"); rd_end = 0;
        cycle("pre_arbit2");
        chk("aref_after_read", aref_en, 1'b1);
        aref_req = 0; rd_req = 0; wr_req = 1;
        aref_end = 1; cycle("pre_aref"); aref_end = 0;
        cycle("pre_arbit3"); cycle("pre_wr1");
        aref_req = 1;
        cycle("pre_wr2");
        chk("wr_wait_set", {wr_wait, wr_dq_oe}, 2'b11);
        do_reset();

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            init_done = ($urandom_range(0, 3) != 0);
            if ((m_own == 1) && m_fresh) aref_req = 0;
            else if (!aref_req && $urandom_range(0, 15) == 0) aref_req = 1;
            if ($urandom_range(0, 5) == 0) wr_req = ~wr_req;
            if ($urandom_range(0, 5) == 0) rd_req = ~rd_req;
            aref_end = ($urandom_range(0, 7) == 0);
            wr_end   = ($urandom_range(0, 9) == 0);
            rd_end   = ($urandom_range(0, 9) == 0);
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
